// File: rtl/softmax_test_seq.sv
// Stimulus sequencer for a softmax unit: replays stored vectors, waits for each result and
// scores the lane sum. Define SEQ_SUM_CHECK_EN to grade sums against 1024 +/- TOL.
module softmax_test_seq #(
    parameter int unsigned N       = 64,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TOL     = 16,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned NW     = $clog2(DEPTH + 1),
    localparam int unsigned SW     = 16 + $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [N*16-1:0] ld_data,
    input  logic [NW-1:0]   num_vec,
    input  logic            start,
    input  logic            loop,
    input  logic            stop,
    output logic            valid_in,
    output logic            en,
    output logic [N*16-1:0] in_x_flat,
    input  logic            valid_out,
    input  logic [N*16-1:0] prob_flat,
    output logic            busy,
    output logic            done,
    output logic            timeout_err,
    output logic [AW-1:0]   cur_idx,
    output logic [15:0]     pass_cnt,
    output logic [15:0]     fail_cnt,
    output logic [SW-1:0]   last_sum
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [N*16-1:0]   mem [DEPTH];
    logic [N*16-1:0]   in_x_q;
    logic [N*16-1:0]   cap_q;
    logic [AW-1:0]     idx_q, idx_d;
    logic [NW-1:0]     num_vec_q;
    logic              loop_q, stop_q;
    logic [CW-1:0]     wcnt_q;
    logic [15:0]       pass_q, fail_q;
    logic [SW-1:0]     sum_q, sum_c;
    logic              terr_q;
    logic              ok_c;
    logic              last_c;
    logic              start_run, capture, tmo, chk, adv;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign last_c = (NW'(idx_q) == num_vec_q - NW'(1));

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) begin
            sum_c = sum_c + SW'(cap_q[i*16 +: 16]);
        end
    end

`ifdef SEQ_SUM_CHECK_EN
    always_comb begin
        if (sum_c >= SW'(1024)) begin
            ok_c = (sum_c - SW'(1024)) <= SW'(TOL);
        end else begin
            ok_c = (SW'(1024) - sum_c) <= SW'(TOL);
        end
    end
`else
    assign ok_c = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        start_run = 1'b0;
        capture   = 1'b0;
        tmo       = 1'b0;
        chk       = 1'b0;
        adv       = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_run = 1'b1;
                    idx_d     = '0;
                    state_d   = (num_vec == '0) ? StDone : StDrive;
                end
            end
            StDrive: state_d = StWait;
            StWait: begin
                if (valid_out) begin
                    capture = 1'b1;
                    state_d = StCheck;
                end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
                    tmo = 1'b1;
                    adv = 1'b1;
                end
            end
            StCheck: begin
                chk = 1'b1;
                adv = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // A pending stop wins over both wrap and increment.
        if (adv) begin
            if (stop_q || stop) begin
                state_d = StDone;
            end else if (last_c) begin
                if (loop_q) begin
                    idx_d   = '0;
                    state_d = StDrive;
                end else begin
                    state_d = StDone;
                end
            end else begin
                idx_d   = idx_q + AW'(1);
                state_d = StDrive;
            end
        end
    end

    // Vector memory survives reset.
    always_ff @(posedge clk) begin
        if (ld_en && (state_q == StIdle || state_q == StDone)) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            in_x_q    <= '0;
            cap_q     <= '0;
            num_vec_q <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            wcnt_q    <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            sum_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_d == StDrive) begin
                in_x_q <= mem[idx_d];
            end
            if (start_run) begin
                num_vec_q <= num_vec;
                loop_q    <= loop;
                stop_q    <= 1'b0;
            end else if (busy && stop) begin
                stop_q <= 1'b1;
            end
            if (state_q == StDrive) begin
                wcnt_q <= '0;
            end else if (state_q == StWait) begin
                wcnt_q <= wcnt_q + CW'(1);
            end
            if (capture) begin
                cap_q <= prob_flat;
            end
            if (start_run) begin
                pass_q <= '0;
                fail_q <= '0;
                terr_q <= 1'b0;
            end else if (chk) begin
                sum_q <= sum_c;
                if (ok_c) begin
                    pass_q <= sat_inc(pass_q);
                end else begin
                    fail_q <= sat_inc(fail_q);
                end
            end else if (tmo) begin
                terr_q <= 1'b1;
                fail_q <= sat_inc(fail_q);
            end
        end
    end

    assign valid_in    = (state_q == StDrive);
    assign en          = (state_q == StDrive) || (state_q == StWait);
    assign busy        = (state_q == StDrive) || (state_q == StWait) || (state_q == StCheck);
    assign done        = (state_q == StDone);
    assign timeout_err = terr_q;
    assign in_x_flat   = in_x_q;
    assign cur_idx     = idx_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign last_sum    = sum_q;

endmodule
